monte_carlo_engine: RTL and testbench
=====================================

// Module: monte_carlo_engine
// PURPOSE
//  Multi-lane Monte Carlo hit counter; successor to the single-lane estimator FSM.
//  N_LANES samplers draw (x,y,t) from per-lane LFSRs, evaluate f=A*x+B*y, count hits t<f.
//  Runs exactly num_iter samples per job under a start/busy/done handshake with abort.
//  Sits between the host register block and the result/readout logic.
// PARAMETERS
//  WIDTH    4  bits of x and y
//  ITER_W   16 width of num_iter, hit_count, sample_count
//  N_LANES  4  parallel samplers, 1..16
//  A        1  x coefficient, >=0
//  B        1  y coefficient, >=A, and A+B>=1
//  localparam F_W = WIDTH+$clog2(A+B+1); elaboration error unless 2*WIDTH+F_W<=32
// PORTS
//  clk          in  1       clock, all state on rising edge
//  rst_n        in  1       asynchronous active-low reset
//  start        in  1       job request; sampled only in IDLE or DONE
//  abort        in  1       cancel running job
//  num_iter     in  ITER_W  samples per job; latched on accepted start
//  seed         in  32      base seed; latched on accepted start
//  busy         out 1       high in SEED/SAMPLE/EVAL/ACCUM
//  done         out 1       high in DONE, held until next start
//  hit_count    out ITER_W  hits of last completed job
//  sample_count out ITER_W  samples of last completed job (== num_iter)
// BEHAVIOUR
//  Reset: state IDLE; busy, done, hit_count, sample_count = 0; LFSRs = 0.
//  Lane LFSR: 32b Fibonacci, poly x^32+x^22+x^2+x+1, shifts left, fb into bit0.
//  Lane i seed = seed ^ ((i+1)*32'h9E3779B9); if result is 0, load 32'h1.
//  Lane draw: x=lfsr[WIDTH-1:0], y=lfsr[2W-1:W], t=lfsr[2W+F_W-1:2W].
//  f = A*x+B*y in F_W bits (no overflow by construction); hit = (t < f), unsigned.
//  FSM:
//   IDLE: start -> SEED (latch num_iter, seed; clear internal hits/remaining).
//   SEED: load all LFSRs; remaining=num_iter; -> DONE if num_iter==0 else SAMPLE.
//   SAMPLE: step every LFSR once -> EVAL.
//   EVAL: register f and hit per lane; lane i valid iff i < remaining -> ACCUM.
//   ACCUM: hits += popcount(valid&hit); remaining -= min(remaining,N_LANES);
//          -> DONE if new remaining==0 else SAMPLE.
//   DONE: copy hits/num_iter to hit_count/sample_count on entry; start -> SEED.
//  Latency: edge sampling start = 0; done rises at edge 1+3*ceil(num_iter/N_LANES).
//  Partial last round: masked lanes step their LFSR but never count.
//  start while busy: ignored. start and abort same cycle in IDLE/DONE: start wins.
//  abort while busy: -> IDLE next edge; done=0; hit_count/sample_count keep old job.
//  start in DONE: done drops next edge; outputs keep old values until new DONE.
//  Internal hit accumulator ITER_W bits; cannot overflow since hits <= num_iter.
//  rst_n low mid-job: immediate return to reset state, no partial results kept.
// CONFIGURATION
//  MC_PROGRESS_EN defined: extra output progress [ITER_W] = samples counted so far
//   in current job (num_iter-remaining), 0 in IDLE, frozen at num_iter in DONE.
//  Undefined: no progress port, no extra logic; all other behaviour identical.
// TESTING (WIDTH=4,ITER_W=16,N_LANES=4,A=1,B=1 unless noted; scoreboard = C model)
//  num_iter=0, start pulse -> done at edge 1, hit_count=0, sample_count=0, busy 1 cycle.
//  num_iter=10, seed=32'h1234 -> done at edge 10, sample_count=10, hit_count==model,
//   lanes 2,3 masked in round 3.
//  Same job run twice with seed=32'hACE1 -> identical hit_count; seed=0 -> no lockup.
//  num_iter=1000, abort at edge 50 -> IDLE at edge 51, done=0, outputs = previous job.
//  rst_n low at edge 20 of a 100-sample job -> all outputs 0 at once, restart exact.
//  N_LANES=1, A=0,B=3, num_iter=65535 -> sample_count=65535, hit_count<=65535 == model;
//   with MC_PROGRESS_EN, progress monotonic in steps of N_LANES.

Source files
------------

// File: rtl/monte_carlo_engine_if.sv
// Host-side handshake and result bus of the Monte Carlo hit counter.
// Optional MC_PROGRESS_EN adds a live progress count to the bus.
interface monte_carlo_engine_if #(
    parameter int ITER_W = 16
);
    logic              start;
    logic              abort;
    logic [ITER_W-1:0] num_iter;
    logic [31:0]       seed;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] hit_count;
    logic [ITER_W-1:0] sample_count;
`ifdef MC_PROGRESS_EN
    logic [ITER_W-1:0] progress;
`endif

    modport master (
        output start, abort, num_iter, seed,
        input  busy, done, hit_count, sample_count
`ifdef MC_PROGRESS_EN
        , input progress
`endif
    );

    modport slave (
        input  start, abort, num_iter, seed,
        output busy, done, hit_count, sample_count
`ifdef MC_PROGRESS_EN
        , output progress
`endif
    );
endinterface

// File: rtl/monte_carlo_engine.sv
// monte_carlo_engine: N_LANES parallel LFSR samplers draw (x,y,t), evaluate
// f = A*x + B*y and count hits t < f over exactly num_iter samples per job.
// Start/busy/done handshake with abort. Optional macro MC_PROGRESS_EN adds a
// progress output (samples counted so far in the current job).
module monte_carlo_engine #(
    parameter int WIDTH   = 4,
    parameter int ITER_W  = 16,
    parameter int N_LANES = 4,
    parameter int A       = 1,
    parameter int B       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    monte_carlo_engine_if.slave   bus
);
    localparam int F_W  = WIDTH + $clog2(A + B + 1);
    localparam int T_LO = 2 * WIDTH;
    localparam int T_HI = 2 * WIDTH + F_W - 1;

    if ((2 * WIDTH + F_W > 32) || (N_LANES < 1) || (N_LANES > 16) ||
        (A < 0) || (B < A) || (A + B < 1)) begin : g_param_check
        $error("monte_carlo_engine: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEED   = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EVAL   = 3'd3,
        ST_ACCUM  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                accept_s;
    logic [ITER_W-1:0]   num_iter_r;
    logic [31:0]         seed_r;
    logic [ITER_W-1:0]   remaining_r;
    logic [ITER_W-1:0]   hits_r;
    logic [ITER_W-1:0]   step_s;
    logic [ITER_W-1:0]   remaining_acc_s;
    logic [ITER_W-1:0]   hits_acc_s;
    logic [31:0]         lfsr_r [N_LANES];
    logic [N_LANES-1:0]  hit_s;
    logic [N_LANES-1:0]  valid_s;
    logic [N_LANES-1:0]  hit_r;
    logic [N_LANES-1:0]  valid_r;
    logic                busy_r;
    logic                done_r;
    logic [ITER_W-1:0]   hit_count_r;
    logic [ITER_W-1:0]   sample_count_r;

    // Fibonacci step for x^32+x^22+x^2+x+1, shifting left, feedback into bit 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    // Per-lane seed decorrelated by a golden-ratio multiple; zero would lock up.
    function automatic logic [31:0] lane_seed(input logic [31:0] base, input logic [4:0] lane);
        logic [31:0] s;
        s = base ^ ((32'(lane) + 32'd1) * 32'h9E3779B9);
        if (s == 32'd0) begin
            s = 32'd1;
        end else begin
            s = s;
        end
        return s;
    endfunction

    // Hit test on the low bits of one lane's state: t < A*x + B*y, unsigned.
    function automatic logic lane_hit(input logic [T_HI:0] v);
        logic [F_W-1:0] x_v;
        logic [F_W-1:0] y_v;
        logic [F_W-1:0] t_v;
        logic [F_W-1:0] f_v;
        x_v = F_W'(v[WIDTH-1:0]);
        y_v = F_W'(v[2*WIDTH-1:WIDTH]);
        t_v = v[T_HI:T_LO];
        f_v = F_W'(A) * x_v + F_W'(B) * y_v;
        return (t_v < f_v);
    endfunction

    // Number of set bits in a lane mask.
    function automatic logic [ITER_W-1:0] popcount(input logic [N_LANES-1:0] v);
        logic [ITER_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_LANES; i++) begin
            c = c + ITER_W'(v[i]);
        end
        return c;
    endfunction

    // Per-lane hit evaluation and mask of lanes still inside the job.
    always_comb begin
        hit_s   = '0;
        valid_s = '0;
        for (int i = 0; i < N_LANES; i++) begin
            hit_s[i]   = lane_hit(lfsr_r[i][T_HI:0]);
            valid_s[i] = (ITER_W'(i) < remaining_r);
        end
    end

    // Round bookkeeping: samples consumed this round and the updated totals.
    always_comb begin
        step_s = remaining_r;
        if (remaining_r > ITER_W'(N_LANES)) begin
            step_s = ITER_W'(N_LANES);
        end else begin
            step_s = remaining_r;
        end
        remaining_acc_s = remaining_r - step_s;
        hits_acc_s      = hits_r + popcount(valid_r & hit_r);
    end

    // Next-state logic; abort overrides every busy state, start wins in IDLE/DONE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_s  = ST_SEED;
                    accept_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SEED: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (num_iter_r == '0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (remaining_acc_s == '0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SAMPLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Lane LFSRs: seeded in SEED, stepped once per SAMPLE (masked lanes too).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LANES; i++) begin
                lfsr_r[i] <= 32'd0;
            end
        end else begin
            case (state_r)
                ST_SEED: begin
                    for (int i = 0; i < N_LANES; i++) begin
                        lfsr_r[i] <= lane_seed(seed_r, 5'(i));
                    end
                end
                ST_SAMPLE: begin
                    for (int i = 0; i < N_LANES; i++) begin
                        lfsr_r[i] <= lfsr_step(lfsr_r[i]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Job parameters, remaining-sample counter, lane results and hit accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_iter_r  <= '0;
            seed_r      <= 32'd0;
            remaining_r <= '0;
            hits_r      <= '0;
            hit_r       <= '0;
            valid_r     <= '0;
        end else if (accept_s) begin
            num_iter_r  <= bus.num_iter;
            seed_r      <= bus.seed;
            remaining_r <= '0;
            hits_r      <= '0;
        end else begin
            case (state_r)
                ST_SEED: begin
                    remaining_r <= num_iter_r;
                end
                ST_EVAL: begin
                    hit_r   <= hit_s;
                    valid_r <= valid_s;
                end
                ST_ACCUM: begin
                    hits_r      <= hits_acc_s;
                    remaining_r <= remaining_acc_s;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status and results; results only change on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            hit_count_r    <= '0;
            sample_count_r <= '0;
        end else begin
            busy_r <= (state_s inside {ST_SEED, ST_SAMPLE, ST_EVAL, ST_ACCUM});
            done_r <= (state_s == ST_DONE);
            if ((state_s == ST_DONE) && (state_r != ST_DONE)) begin
                hit_count_r    <= (state_r == ST_ACCUM) ? hits_acc_s : hits_r;
                sample_count_r <= num_iter_r;
            end else begin
                hit_count_r    <= hit_count_r;
                sample_count_r <= sample_count_r;
            end
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.hit_count    = hit_count_r;
    assign bus.sample_count = sample_count_r;

`ifdef MC_PROGRESS_EN
    logic [ITER_W-1:0] progress_r;

    // Samples counted so far: zero in IDLE/SEED, advanced after each round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            progress_r <= '0;
        end else if ((state_s == ST_IDLE) || (state_s == ST_SEED)) begin
            progress_r <= '0;
        end else if (state_r == ST_ACCUM) begin
            progress_r <= num_iter_r - remaining_acc_s;
        end else begin
            progress_r <= progress_r;
        end
    end

    assign bus.progress = progress_r;
`endif

endmodule

// File: tb/tb_monte_carlo_engine.sv
// Scoreboard bench for monte_carlo_engine: jobs push model results into a
// queue, a monitor pops and compares on every rising edge of done.
module tb_monte_carlo_engine;
    localparam int WIDTH   = 4;
    localparam int ITER_W  = 16;
    localparam int N_LANES = 4;
    localparam int A       = 1;
    localparam int B       = 1;
    localparam int F_W     = WIDTH + $clog2(A + B + 1);

    typedef struct {
        int unsigned hits;
        int unsigned samples;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int unsigned last_hc;
    int unsigned last_sc;
    logic prev_done;

    monte_carlo_engine_if #(.ITER_W(ITER_W)) bus ();

    monte_carlo_engine #(
        .WIDTH(WIDTH), .ITER_W(ITER_W), .N_LANES(N_LANES), .A(A), .B(B)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: run num_iter samples round by round with plain arithmetic.
    function automatic int unsigned model_hits(input logic [31:0] sd, input int n);
        logic [31:0] s [N_LANES];
        int unsigned hits;
        int unsigned v, x, y, t;
        hits = 0;
        for (int i = 0; i < N_LANES; i++) begin
            s[i] = sd ^ (32'(i + 1) * 32'h9E3779B9);
            if (s[i] == 32'd0) s[i] = 32'd1;
        end
        for (int r = 0; r * N_LANES < n; r++) begin
            for (int i = 0; i < N_LANES; i++) begin
                s[i] = {s[i][30:0], s[i][31] ^ s[i][21] ^ s[i][1] ^ s[i][0]};
                if (r * N_LANES + i < n) begin
                    v = s[i];
                    x = v % (1 << WIDTH);
                    y = (v >> WIDTH) % (1 << WIDTH);
                    t = (v >> (2 * WIDTH)) % (1 << F_W);
                    if (t < A * x + B * y) hits++;
                end
            end
        end
        return hits;
    endfunction

    // Monitor: every done rising edge consumes one expected result.
    initial begin
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("hit_count", bus.hit_count, e.hits);
                    check("sample_count", bus.sample_count, e.samples);
`ifdef MC_PROGRESS_EN
                    check("progress_final", bus.progress, e.samples);
`endif
                end
            end
            prev_done = bus.done;
        end
    end

    task automatic run_job(input logic [31:0] sd, input int n, input bit with_abort, input bit poke);
        exp_t e;
        int   exp_lat;
        int   lat;
        int   busy_cyc;
        exp_lat  = 1 + 3 * ((n + N_LANES - 1) / N_LANES);
        lat      = -1;
        busy_cyc = 0;
        e.hits    = model_hits(sd, n);
        e.samples = n;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.abort    = with_abort;
        bus.num_iter = ITER_W'(n);
        bus.seed     = sd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check("done_drop", bus.done, 0);
        check("hold_old_hits", bus.hit_count, last_hc);
        check("hold_old_samples", bus.sample_count, last_sc);
        if (bus.busy) busy_cyc++;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int k = 1; k <= exp_lat + 20; k++) begin
            @(posedge clk);
            #1;
            if (poke && k == 3) begin
                bus.start    = 1'b1;
                bus.num_iter = 16'd7;
            end
            if (poke && k == 4) bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_cyc++;
        end
        bus.start = 1'b0;
        check("done_latency", lat, exp_lat);
        check("busy_cycles", busy_cyc, exp_lat);
        last_hc = e.hits;
        last_sc = n;
    endtask

    task automatic abort_job(input logic [31:0] sd, input int n, input int ab_edge);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.num_iter = ITER_W'(n);
        bus.seed     = sd;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (ab_edge - 1) @(posedge clk);
        #1;
        check("abort_busy_before", bus.busy, 1);
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_keep_hits", bus.hit_count, last_hc);
        check("abort_keep_samples", bus.sample_count, last_sc);
`ifdef MC_PROGRESS_EN
        check("abort_progress", bus.progress, 0);
`endif
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_stays_idle", bus.busy, 0);
    endtask

    task automatic reset_mid_job(input logic [31:0] sd, input int n);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.num_iter = ITER_W'(n);
        bus.seed     = sd;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hits", bus.hit_count, 0);
        check("rst_samples", bus.sample_count, 0);
        last_hc = 0;
        last_sc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_job(sd, n, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        last_hc      = 0;
        last_sc      = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.num_iter = '0;
        bus.seed     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_hits", bus.hit_count, 0);
        check("reset_samples", bus.sample_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(32'h0000_0000, 0, 1'b0, 1'b0);
        run_job(32'h0000_1234, 10, 1'b0, 1'b0);
        run_job(32'h0000_ACE1, 25, 1'b0, 1'b0);
        run_job(32'h0000_ACE1, 25, 1'b0, 1'b0);
        run_job(32'h0000_0000, 13, 1'b0, 1'b0);
        run_job(32'h9E37_79B9, 17, 1'b0, 1'b0);
        run_job(32'h0000_ACE1, 8, 1'b1, 1'b0);
        run_job(32'h0000_55AA, 10, 1'b0, 1'b1);
        abort_job(32'hDEAD_BEEF, 1000, 50);
        run_job(32'hCAFE_0001, 5, 1'b1, 1'b0);
        reset_mid_job(32'h0BAD_F00D, 100);
        for (int j = 0; j < 6; j++) begin
            run_job($urandom, int'($urandom_range(1, 40)), 1'b0, 1'b0);
        end
        run_job($urandom, 65535, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("done_held", bus.done, 1);
        check("hits_held", bus.hit_count, last_hc);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
